keypad_scanner: RTL and testbench

- Input-side counterpart of the multiplexed seven-segment output path: scans a 4x4 matrix keypad by strobing columns and sensing rows.
- Synchronises and debounces the row inputs, then encodes each press as a 4-bit key code.
- Presents the code to the CPU input register with a valid/ack handshake.
- Sits beside the display driver in the top level and feeds the CPU's input port.

---
 rtl/keypad_scanner_pkg.sv | 40 ++++
 rtl/keypad_scanner_if.sv | 27 ++
 rtl/keypad_scanner_sync_2ff.sv | 28 ++
 rtl/keypad_scanner.sv | 212 +++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/keypad_scanner_pkg.sv
// Shared types, matrix dimensions and small helpers for the 4x4 keypad scanner.
package keypad_scanner_pkg;

    localparam int KEY_W    = 4;
    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;

    typedef logic [1:0] row_idx_t;
    typedef logic [1:0] col_idx_t;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } kp_state_e;

    // Active-low one-hot strobe for the given column.
    function automatic logic [NUM_COLS-1:0] col_strobe(input col_idx_t col);
        return ~(4'b0001 << col);
    endfunction

    // Index of the lowest-numbered row pulled low; rows are active-low.
    function automatic row_idx_t lowest_low_row(input logic [NUM_ROWS-1:0] rows);
        row_idx_t idx;
        idx = 2'd0;
        for (int i = NUM_ROWS - 1; i >= 0; i--) begin
            if (!rows[i]) begin
                idx = 2'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    function automatic logic [KEY_W-1:0] key_encode(input row_idx_t row, input col_idx_t col);
        return {row, col};
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Key-code handshake bundle between the keypad scanner (master) and the CPU input port (slave).
interface keypad_scanner_if;
    import keypad_scanner_pkg::*;

    logic [KEY_W-1:0] key_code;
    logic             key_valid;
    logic             key_ack;
    logic             key_down;
    logic             overrun;

    modport master (
        output key_code,
        output key_valid,
        output key_down,
        output overrun,
        input  key_ack
    );

    modport slave (
        input  key_code,
        input  key_valid,
        input  key_down,
        input  overrun,
        output key_ack
    );

endinterface

// File: rtl/keypad_scanner_sync_2ff.sv
// Generic-width two-flop synchroniser for asynchronous level inputs.
module sync_2ff #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Two back-to-back capture stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column strobe, row debounce, key encoding and valid/ack handshake.
// Optional auto-repeat while a key is held is enabled with `define KEYPAD_REPEAT_EN.
module keypad_scanner
    import keypad_scanner_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 20000,
    parameter int REPEAT_DELAY = 5000000
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic [NUM_COLS-1:0] col_drive,
    input  logic [NUM_ROWS-1:0] row_sense,
    keypad_scanner_if.master    kif
);

    localparam int SCAN_W = $clog2(SCAN_DIV);
    localparam int DEB_W  = $clog2(DEBOUNCE_CNT);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CNT - 1);

    if (SCAN_DIV < 4 || DEBOUNCE_CNT < 2 || REPEAT_DELAY < 2) begin : g_param_check
        $error("keypad_scanner: parameter below its minimum");
    end

    logic [NUM_ROWS-1:0] rows_s;
    logic                row_low_s;
    logic                emit_s;

    kp_state_e           state_q,     state_d;
    col_idx_t            col_q,       col_d;
    logic [NUM_COLS-1:0] col_drive_q, col_drive_d;
    logic [SCAN_W-1:0]   scan_cnt_q,  scan_cnt_d;
    logic [DEB_W-1:0]    deb_cnt_q,   deb_cnt_d;
    row_idx_t            cand_row_q,  cand_row_d;
    col_idx_t            cand_col_q,  cand_col_d;
    logic [KEY_W-1:0]    key_code_q,  key_code_d;
    logic                key_valid_q, key_valid_d;
    logic                key_down_q,  key_down_d;
    logic                overrun_q,   overrun_d;

`ifdef KEYPAD_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_DELAY);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_DELAY - 1);
    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
`endif

    sync_2ff #(
        .WIDTH   (NUM_ROWS),
        .RST_VAL ({NUM_ROWS{1'b1}})
    ) u_row_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (row_sense),
        .q_o   (rows_s)
    );

    assign row_low_s = ~rows_s[cand_row_q];

    // Scan / debounce / hold sequencing and the accept pulse.
    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        scan_cnt_d = scan_cnt_q;
        deb_cnt_d  = deb_cnt_q;
        cand_row_d = cand_row_q;
        cand_col_d = cand_col_q;
        key_down_d = key_down_q;
        emit_s     = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        rep_cnt_d  = rep_cnt_q;
`endif

        case (state_q)
            SCAN: begin
                if (scan_cnt_q == SCAN_LAST) begin
                    scan_cnt_d = {SCAN_W{1'b0}};
                    if (rows_s == 4'hF) begin
                        col_d = col_q + 2'd1;
                    end else begin
                        cand_col_d = col_q;
                        cand_row_d = lowest_low_row(rows_s);
                        deb_cnt_d  = {DEB_W{1'b0}};
                        state_d    = DEBOUNCE;
                    end
                end else begin
                    scan_cnt_d = scan_cnt_q + SCAN_W'(1'b1);
                end
            end

            DEBOUNCE: begin
                if (row_low_s) begin
                    if (deb_cnt_q == DEB_LAST) begin
                        emit_s     = 1'b1;
                        key_down_d = 1'b1;
                        deb_cnt_d  = {DEB_W{1'b0}};
                        state_d    = HELD;
`ifdef KEYPAD_REPEAT_EN
                        rep_cnt_d  = {REP_W{1'b0}};
`endif
                    end else begin
                        deb_cnt_d = deb_cnt_q + DEB_W'(1'b1);
                    end
                end else begin
                    // Bounce: give up on this candidate and move on to the next column.
                    deb_cnt_d  = {DEB_W{1'b0}};
                    scan_cnt_d = {SCAN_W{1'b0}};
                    col_d      = col_q + 2'd1;
                    state_d    = SCAN;
                end
            end

            HELD: begin
                if (row_low_s) begin
                    deb_cnt_d = {DEB_W{1'b0}};
`ifdef KEYPAD_REPEAT_EN
                    if (rep_cnt_q == REP_LAST) begin
                        emit_s    = 1'b1;
                        rep_cnt_d = {REP_W{1'b0}};
                    end else begin
                        rep_cnt_d = rep_cnt_q + REP_W'(1'b1);
                    end
`endif
                end else begin
`ifdef KEYPAD_REPEAT_EN
                    rep_cnt_d = {REP_W{1'b0}};
`endif
                    if (deb_cnt_q == DEB_LAST) begin
                        key_down_d = 1'b0;
                        deb_cnt_d  = {DEB_W{1'b0}};
                        scan_cnt_d = {SCAN_W{1'b0}};
                        col_d      = col_q + 2'd1;
                        state_d    = SCAN;
                    end else begin
                        deb_cnt_d = deb_cnt_q + DEB_W'(1'b1);
                    end
                end
            end

            default: begin
                state_d    = SCAN;
                col_d      = 2'd0;
                scan_cnt_d = {SCAN_W{1'b0}};
                deb_cnt_d  = {DEB_W{1'b0}};
                key_down_d = 1'b0;
            end
        endcase

        col_drive_d = col_strobe(col_d);
    end

    // Consumer handshake; an accept racing a same-cycle ack replaces the key instead of overrunning.
    always_comb begin
        key_code_d  = key_code_q;
        key_valid_d = key_valid_q;
        overrun_d   = overrun_q;
        if (emit_s) begin
            if (key_valid_q && !kif.key_ack) begin
                overrun_d = 1'b1;
            end else begin
                key_code_d  = key_encode(cand_row_q, cand_col_q);
                key_valid_d = 1'b1;
            end
        end else if (kif.key_ack && key_valid_q) begin
            key_valid_d = 1'b0;
        end else begin
            key_valid_d = key_valid_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SCAN;
            col_q       <= 2'd0;
            col_drive_q <= 4'b1110;
            scan_cnt_q  <= {SCAN_W{1'b0}};
            deb_cnt_q   <= {DEB_W{1'b0}};
            cand_row_q  <= 2'd0;
            cand_col_q  <= 2'd0;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            key_down_q  <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt_q   <= {REP_W{1'b0}};
`endif
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            col_drive_q <= col_drive_d;
            scan_cnt_q  <= scan_cnt_d;
            deb_cnt_q   <= deb_cnt_d;
            cand_row_q  <= cand_row_d;
            cand_col_q  <= cand_col_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_down_q  <= key_down_d;
            overrun_q   <= overrun_d;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt_q   <= rep_cnt_d;
`endif
        end
    end

    assign col_drive     = col_drive_q;
    assign kif.key_code  = key_code_q;
    assign kif.key_valid = key_valid_q;
    assign kif.key_down  = key_down_q;
    assign kif.overrun   = overrun_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a physical 4x4 key matrix plus a timing/handshake reference model.
module tb_keypad_scanner;
    import keypad_scanner_pkg::*;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 8;
    localparam int REP_DLY  = 64;
`ifdef KEYPAD_REPEAT_EN
    localparam bit REP_ON = 1'b1;
`else
    localparam bit REP_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  col_drive;
    logic [3:0]  row_sense;
    logic [15:0] pressed;

    keypad_scanner_if kif ();

    keypad_scanner #(
        .SCAN_DIV     (SCAN_DIV),
        .DEBOUNCE_CNT (DEB),
        .REPEAT_DELAY (REP_DLY)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .col_drive (col_drive),
        .row_sense (row_sense),
        .kif       (kif)
    );

    always #5 clk = ~clk;

    // Passive matrix: a pressed key pulls its row low while its column is strobed.
    always_comb begin
        row_sense = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !col_drive[c]) row_sense[r] = 1'b0;
    end

    int         total_cnt, bad_cnt;
    int         ecount, anchor_e, anchor_col, ack_mode, valid_rises;
    logic       exp_valid, exp_down, exp_ovr, prev_valid;
    logic [3:0] exp_code;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        if (obs !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0h, want %0h (edge %0d)", tag, obs, exp, ecount);
        end
    endtask

    function automatic int idle_col(input int e);
        return (anchor_col + (e - anchor_e) / SCAN_DIV) % 4;
    endfunction

    task automatic set_ack(input int mode);
        ack_mode    = mode;
        kif.key_ack = (mode == 2);
    endtask

    // One clock edge: advance the model, compare all outputs, then drive the next ack.
    task automatic run_edge(input bit emit, input logic [3:0] ncode, input int ecol, input bit edown);
        logic [3:0] ec;
        @(posedge clk);
        ecount++;
        if (emit) begin
            if (exp_valid && !kif.key_ack) exp_ovr = 1'b1;
            else begin
                exp_code  = ncode;
                exp_valid = 1'b1;
            end
        end else if (kif.key_ack && exp_valid) begin
            exp_valid = 1'b0;
        end
        exp_down = edown;
        #1;
        if (ecol >= 0) begin
            ec = ~(4'b0001 << ecol);
            check_val("col_drive", col_drive, ec);
        end
        check_val("key_valid", kif.key_valid, exp_valid);
        check_val("key_code", kif.key_code, exp_code);
        check_val("key_down", kif.key_down, exp_down);
        check_val("overrun", kif.overrun, exp_ovr);
        if (kif.key_valid && !prev_valid) valid_rises++;
        prev_valid = kif.key_valid;
        @(negedge clk);
        case (ack_mode)
            0:       kif.key_ack = 1'b0;
            1:       kif.key_ack = ($urandom_range(0, 2) == 0);
            default: kif.key_ack = 1'b1;
        endcase
    endtask

    task automatic run_idle(input int n);
        for (int i = 0; i < n; i++) run_edge(1'b0, 4'h0, idle_col(ecount + 1), 1'b0);
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        pressed     = 16'h0;
        kif.key_ack = 1'b0;
        #1;
        check_val("rst_col", col_drive, 4'b1110);
        check_val("rst_valid", kif.key_valid, 1'b0);
        check_val("rst_code", kif.key_code, 4'd0);
        check_val("rst_down", kif.key_down, 1'b0);
        check_val("rst_ovr", kif.overrun, 1'b0);
        exp_valid = 1'b0; exp_down = 1'b0; exp_ovr = 1'b0; exp_code = 4'd0;
        prev_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n      = 1'b1;
        ecount     = 0;
        anchor_e   = 0;
        anchor_col = 0;
    endtask

    // Press key (r,c) (plus optional key (r2,c) in the same column) and hold for 'hold'
    // cycles after acceptance. Timing follows from the scan/debounce rules:
    // sample at the end of the column slot, DEB cycles of debounce, 2-cycle input
    // synchroniser plus DEB stable-high cycles to release.
    task automatic press_key(input int r, input int c, input int hold, input int r2, input bit abort_mid);
        int p, k, cstart, s, v, rr, d, e, ecol;
        bit emit;
        logic [3:0] code;
        p = ecount;
        pressed[r*4+c] = 1'b1;
        if (r2 >= 0) pressed[r2*4+c] = 1'b1;
        k = 0;
        while (!(((anchor_col + k) % 4) == c && anchor_e + SCAN_DIV*k + 1 >= p)) k++;
        cstart = anchor_e + SCAN_DIV*k;
        s      = cstart + SCAN_DIV;
        v      = s + DEB;
        rr     = v + hold;
        d      = rr + 2 + DEB;
        code   = 4'(r*4 + c);
        while (ecount < d) begin
            if (abort_mid && ecount == s + 3) return;
            e    = ecount + 1;
            emit = (e == v) || (REP_ON && e > v && ((e - v) % REP_DLY) == 0 && e <= rr + 2);
            ecol = (e >= d) ? (c + 1) % 4 : ((e >= cstart) ? c : idle_col(e));
            run_edge(emit, code, ecol, (e >= v && e < d));
            if (ecount == rr) begin
                pressed[r*4+c] = 1'b0;
                if (r2 >= 0) pressed[r2*4+c] = 1'b0;
            end
        end
        anchor_e   = d;
        anchor_col = (c + 1) % 4;
    endtask

    // Row 0 / col 3 chatter: 3 cycles low, 1 high; must never produce a key.
    task automatic bounce(input int cycles);
        bit seen3, found;
        for (int i = 0; i < cycles; i++) begin
            pressed[3] = (i % 4 != 3);
            run_edge(1'b0, 4'h0, -1, 1'b0);
        end
        pressed[3] = 1'b0;
        seen3 = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            run_edge(1'b0, 4'h0, -1, 1'b0);
            if (col_drive == 4'b0111) seen3 = 1'b1;
            else if (seen3 && col_drive == 4'b1110) found = 1'b1;
        end
        check_val("bounce_resume_col0", found, 1'b1);
        anchor_e   = ecount;
        anchor_col = 0;
    endtask

    initial begin
        int r, c, r2;
        rst_n = 1'b0; pressed = 16'h0; kif.key_ack = 1'b0;
        total_cnt = 0; bad_cnt = 0; valid_rises = 0; ack_mode = 0;
        @(negedge clk);
        do_reset();
        run_idle(32);

        press_key(2, 1, 40, -1, 1'b0);
        run_idle(3);
        check_val("key9_code", kif.key_code, 4'd9);
        set_ack(2);
        run_idle(2);
        check_val("key9_ack_clear", kif.key_valid, 1'b0);

        press_key(1, 2, 10, 3, 1'b0);
        set_ack(0);
        run_idle(4);

        press_key(1, 1, 20, -1, 1'b0);
        run_idle(5);
        press_key(2, 2, 20, -1, 1'b0);
        check_val("ovr_flag", kif.overrun, 1'b1);
        check_val("ovr_code_kept", kif.key_code, 4'd5);
        set_ack(2);
        run_idle(2);
        check_val("ovr_ack_valid", kif.key_valid, 1'b0);
        check_val("ovr_sticky", kif.overrun, 1'b1);
        set_ack(0);

        bounce(64);
        run_idle(20);

        press_key(0, 0, 10, -1, 1'b1);
        do_reset();
        run_idle(40);
        check_val("rst_mid_no_key", kif.key_valid, 1'b0);

        set_ack(2);
        valid_rises = 0;
        press_key(0, 0, 150, -1, 1'b0);
        check_val("repeat_rises", valid_rises, REP_ON ? 32'd3 : 32'd1);

        for (int t = 0; t < 12; t++) begin
            if ($urandom_range(0, 4) == 0) do_reset();
            set_ack(int'($urandom_range(0, 2)));
            r  = int'($urandom_range(0, 3));
            c  = int'($urandom_range(0, 3));
            r2 = (r < 3 && $urandom_range(0, 1) == 1) ? int'($urandom_range(r + 1, 3)) : -1;
            press_key(r, c, int'($urandom_range(0, 90)), r2, 1'b0);
            run_idle(int'($urandom_range(0, 12)));
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
